// File: rtl/zb_tx_pkg.sv
// Shared definitions for the Zigbee transmit chain.
// Holds the symbol and byte widths, the symbol type, and a helper that gives
// the number of symbols carried by a word of a given width.
package zb_tx_pkg;

    localparam int SYM_W  = 4;
    localparam int BYTE_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    // Number of whole symbols in a word of dataW bits
    function automatic int nsym(input int dataW);
        return dataW / SYM_W;
    endfunction

endpackage

// File: rtl/sym_mux_serializer_if.sv
// Stream bundle for sym_mux_serializer.
// Word side:   inData, inValid in; outReady out.
// Symbol side: outSym, outSymValid, outFirst, outLast out; inSymReady in.
// The slave modport is the serializer's view, the master modport is the
// view of whatever drives words in and takes symbols out.
interface sym_mux_serializer_if #(
    parameter int DATA_W = 8
);
    import zb_tx_pkg::*;

    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              outReady;
    sym_t              outSym;
    logic              outSymValid;
    logic              inSymReady;
    logic              outFirst;
    logic              outLast;

    modport slave (
        input  inData, inValid, inSymReady,
        output outReady, outSym, outSymValid, outFirst, outLast
    );

    modport master (
        output inData, inValid, inSymReady,
        input  outReady, outSym, outSymValid, outFirst, outLast
    );

endinterface

// File: rtl/sym_mux_serializer_mux_n21.sv
// mux_n21: combinational NSYM:1 symbol selector.
// Ports:
//   inSyms  in   NSYM symbols
//   inSel   in   index of the symbol to pass through
//   outSym  out  selected symbol (zero for an index past NSYM-1)
module mux_n21
    import zb_tx_pkg::*;
#(
    parameter int NSYM = 2,
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1
) (
    input  sym_t             inSyms [NSYM],
    input  logic [IDX_W-1:0] inSel,
    output sym_t             outSym
);

    // Walk every input and keep the one whose position matches the select;
    // the default covers select codes that name no symbol.
    always_comb begin
        outSym = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (inSel == IDX_W'(i)) begin
                outSym = inSyms[i];
            end
        end
    end

endmodule

// File: rtl/sym_mux_serializer.sv
// sym_mux_serializer: splits each accepted word into NSYM symbols of SYM_W
// bits and sends them low symbol first on a valid/ready stream.
// Ports:
//   inClk   in  clock, all state changes on the rising edge
//   inRst   in  synchronous active-high reset
//   bus     slave side of sym_mux_serializer_if (word in, symbol out)
// Storage is one word plus a symbol counter; there is no FIFO.
module sym_mux_serializer
    import zb_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input logic                 inClk,
    input logic                 inRst,
    sym_mux_serializer_if.slave bus
);

    localparam int NSYM  = nsym(DATA_W);
    localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    // A word width that is not a whole number of symbols cannot be split.
    if (DATA_W % SYM_W != 0) begin : gBadWidth
        $error("sym_mux_serializer: DATA_W must be a multiple of SYM_W");
    end

    logic [DATA_W-1:0] holdReg;
    logic [CNT_W-1:0]  symCnt;
    logic              busy;

    logic lastSym;
    logic symXfer;
    logic wordAccept;
    sym_t holdSyms [NSYM];
    sym_t muxSym;

    // Slice the held word into its symbols, symbol 0 at the low end.
    for (genvar g = 0; g < NSYM; g++) begin : gSlice
        assign holdSyms[g] = holdReg[g*SYM_W +: SYM_W];
    end

    mux_n21 #(
        .NSYM (NSYM)
    ) uMux (
        .inSyms (holdSyms),
        .inSel  (symCnt),
        .outSym (muxSym)
    );

    assign lastSym    = (symCnt == CNT_W'(NSYM - 1));
    assign symXfer    = busy && bus.inSymReady;
    // Ready looks straight through at inSymReady so a new word can be taken
    // on the same edge that the last symbol leaves, giving bubble-free streaming.
    assign bus.outReady = !busy || (lastSym && bus.inSymReady);
    assign wordAccept   = bus.inValid && bus.outReady;

    assign bus.outSym      = muxSym;
    assign bus.outSymValid = busy;
    assign bus.outFirst    = busy && (symCnt == '0);
    assign bus.outLast     = busy && lastSym;

    // Word/symbol state. A new word takes priority over the last-symbol
    // transfer it coincides with; reset overrides both and drops any
    // partially sent word.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            holdReg <= '0;
            symCnt  <= '0;
            busy    <= 1'b0;
        end else if (wordAccept) begin
            holdReg <= bus.inData;
            symCnt  <= '0;
            busy    <= 1'b1;
        end else if (symXfer) begin
            if (lastSym) begin
                symCnt <= '0;
                busy   <= 1'b0;
            end else begin
                symCnt <= symCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sym_mux_serializer.sv
// Testbench for sym_mux_serializer (DATA_W=8, two symbols per word).
// A directed table covers the named scenarios cycle by cycle; a random
// phase then compares the DUT with a queue-based model of the symbol stream.
module tb_sym_mux_serializer;

    localparam int NSYM = 2;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       symReady;
        logic       chk;
        logic       symChk;
        logic       expValid;
        logic [3:0] expSym;
        logic       expFirst;
        logic       expLast;
        logic       expReady;
    } vec_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    vec_t       vecs[$];
    logic [3:0] modelQ[$];

    sym_mux_serializer_if #(.DATA_W(8)) bus ();

    sym_mux_serializer #(
        .DATA_W (8)
    ) dut (
        .inClk (clock),
        .inRst (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic valid, input logic [7:0] data,
                                input logic symReady, input logic chk, input logic symChk,
                                input logic expValid, input logic [3:0] expSym,
                                input logic expFirst, input logic expLast, input logic expReady);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.symReady = symReady;
        v.chk = chk; v.symChk = symChk; v.expValid = expValid; v.expSym = expSym;
        v.expFirst = expFirst; v.expLast = expLast; v.expReady = expReady;
        return v;
    endfunction

    task automatic checkVal(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] data,
                                 input logic symReady);
        reset          = rst;
        bus.inValid    = valid;
        bus.inData     = data;
        bus.inSymReady = symReady;
    endtask

    task automatic checkOutput(input string tag, input logic symChk, input logic expValid,
                               input logic [3:0] expSym, input logic expFirst,
                               input logic expLast, input logic expReady);
        checkVal({tag, ".valid"}, 8'(bus.outSymValid), 8'(expValid));
        checkVal({tag, ".ready"}, 8'(bus.outReady), 8'(expReady));
        checkVal({tag, ".first"}, 8'(bus.outFirst), 8'(expFirst));
        checkVal({tag, ".last"},  8'(bus.outLast),  8'(expLast));
        if (symChk || expValid) begin
            checkVal({tag, ".sym"}, 8'(bus.outSym), 8'(expSym));
        end
    endtask

    // One random-phase cycle: outputs are predicted from the queue of symbols
    // still owed to the consumer, then the queue advances by the handshakes.
    task automatic modelCycle(input logic rst, input logic valid, input logic [7:0] data,
                              input logic symReady);
        logic       mValid;
        logic       mReady;
        logic [3:0] mSym;
        applyStimulus(rst, valid, data, symReady);
        @(negedge clock);
        mValid = (modelQ.size() != 0);
        mReady = (modelQ.size() == 0) || (modelQ.size() == 1 && symReady);
        mSym   = mValid ? modelQ[0] : 4'h0;
        checkOutput("rnd", 1'b0, mValid, mSym, modelQ.size() == NSYM,
                    modelQ.size() == 1, mReady);
        @(posedge clock);
        #1;
        if (rst) begin
            modelQ.delete();
        end else begin
            if (mValid && symReady) void'(modelQ.pop_front());
            if (valid && mReady) begin
                for (int s = 0; s < NSYM; s++) modelQ.push_back(data[s*4 +: 4]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);

        // rst valid data sr | chk symChk V sym F L R
        vecs.push_back(mk(1, 1, 8'hFF, 1, 0, 0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h3C, 0, 1, 1, 0, 4'h0, 0, 0, 1));
        // single word A7
        vecs.push_back(mk(0, 1, 8'hA7, 1, 1, 1, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'h7, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'hA, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 4'h0, 0, 0, 1));
        // back-to-back 12, 34
        vecs.push_back(mk(0, 1, 8'h12, 1, 1, 0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h34, 1, 1, 0, 1, 4'h2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h34, 1, 1, 0, 1, 4'h1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'h4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'h3, 0, 1, 1));
        // backpressure 5C
        vecs.push_back(mk(0, 1, 8'h5C, 0, 1, 0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 4'hC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 4'hC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 4'hC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'hC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 4'h5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'h5, 0, 1, 1));
        // EE held while 81 is being sent
        vecs.push_back(mk(0, 1, 8'h81, 1, 1, 0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'hEE, 1, 1, 0, 1, 4'h1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hEE, 1, 1, 0, 1, 4'h8, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'hE, 0, 1, 1));
        // reset after symbol 3 of 93: symbol 9 never transfers
        vecs.push_back(mk(0, 1, 8'h93, 1, 1, 0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 4'h3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h77, 0, 1, 0, 1, 4'h9, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 4'h0, 0, 0, 1));

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].symReady);
            @(negedge clock);
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d", i), vecs[i].symChk, vecs[i].expValid,
                            vecs[i].expSym, vecs[i].expFirst, vecs[i].expLast,
                            vecs[i].expReady);
            end
            @(posedge clock);
            #1;
        end

        // Start a word, then hold reset two cycles with random inputs
        modelQ.delete();
        applyStimulus(1'b0, 1'b1, 8'hD4, 1'b1);
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)));
            @(posedge clock);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        checkOutput("rstHold", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #1;

        // Random traffic against the queue model, with rare resets
        for (int n = 0; n < 600; n++) begin
            modelCycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
                       8'($urandom), 1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
